ship_collision: RTL

SHIP_COLLISION -- requirements
Module: ship_collision

---
 rtl/ship_collision_pkg.sv | 29 ++
 rtl/ship_collision_if.sv | 31 +++
 rtl/ship_collision_box_overlap.sv | 26 ++
 rtl/ship_collision.sv | 108 ++++++++++
 4 files changed

// File: rtl/ship_collision_pkg.sv
// Shared definitions for the ship collision block: coordinate widths, sprite
// hit-box sizes, the ship life-cycle state type and a carry-preserving adder.
// Holds the game-wide galaga_lib package, which every ship_collision file imports.
package galaga_lib;

  localparam int unsigned NumHaz = 4;
  localparam int unsigned CoordW = 10;

  // Hit-box extents: a box spans [pos, pos + size] inclusive.
  // The ship sprite is 16x16 pixels.
  localparam logic [CoordW-1:0] ShipXSize = 10'd15;
  localparam logic [CoordW-1:0] ShipYSize = 10'd15;
  localparam logic [CoordW-1:0] HazXSize  = 10'd3;
  localparam logic [CoordW-1:0] HazYSize  = 10'd7;

  typedef enum logic [1:0] {
    ALIVE,
    EXPLODE,
    RESPAWN,
    DEAD
  } shipState_t;

  // Keeps the carry so boxes at the right or bottom edge do not wrap to 0.
  function automatic logic [CoordW:0] extSum(input logic [CoordW-1:0] a,
                                             input logic [CoordW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/ship_collision_if.sv
// Bundle between the game logic (master) and the ship collision block (slave).
// master drives ship and hazard positions and hazard-valid flags, and observes
// the hide flag, per-hazard kill pulses, hit pulse, lives, game-over flag and
// explosion animation index. slave is the collision block's view.
interface ship_collision_if;
  import galaga_lib::*;

  logic [CoordW-1:0]             ShipX;
  logic [CoordW-1:0]             ShipY;
  logic [NumHaz-1:0][CoordW-1:0] HazX;
  logic [NumHaz-1:0][CoordW-1:0] HazY;
  logic [NumHaz-1:0]             HazValid;

  logic                          ShipColl;
  logic [NumHaz-1:0]             HazKill;
  logic                          HitPulse;
  logic [1:0]                    Lives;
  logic                          GameOver;
  logic [2:0]                    ExplodeFrame;

  modport master (
    output ShipX, ShipY, HazX, HazY, HazValid,
    input  ShipColl, HazKill, HitPulse, Lives, GameOver, ExplodeFrame
  );

  modport slave (
    input  ShipX, ShipY, HazX, HazY, HazValid,
    output ShipColl, HazKill, HitPulse, Lives, GameOver, ExplodeFrame
  );

endinterface

// File: rtl/ship_collision_box_overlap.sv
// Combinational inclusive-bounds overlap test between the ship hit box and one
// hazard hit box.
// Ports: ShipX/ShipY ship top-left, HazX/HazY hazard top-left, HazValid
// hazard active flag, Overlap high when the valid hazard touches the ship.
module box_overlap import galaga_lib::*; (
  input  logic [CoordW-1:0] ShipX,
  input  logic [CoordW-1:0] ShipY,
  input  logic [CoordW-1:0] HazX,
  input  logic [CoordW-1:0] HazY,
  input  logic              HazValid,
  output logic              Overlap
);

  logic [CoordW:0] shipRight, shipBottom, hazRight, hazBottom;

  always_comb begin
    shipRight  = extSum(ShipX, ShipXSize);
    shipBottom = extSum(ShipY, ShipYSize);
    hazRight   = extSum(HazX, HazXSize);
    hazBottom  = extSum(HazY, HazYSize);
    Overlap    = HazValid &&
                 ({1'b0, ShipX} <= hazRight)  && ({1'b0, HazX} <= shipRight) &&
                 ({1'b0, ShipY} <= hazBottom) && ({1'b0, HazY} <= shipBottom);
  end

endmodule

// File: rtl/ship_collision.sv
// Ship collision and life-cycle controller, advanced once per video frame.
// A hit while ALIVE starts an explosion (ship hidden), followed by an
// invulnerable respawn period, or by DEAD once no lives remain.
// Ports: frame_clk frame-rate clock, Reset synchronous active-high reset,
// bus slave view of ship_collision_if (positions in, status outputs out).
// All outputs are registered.
module ship_collision import galaga_lib::*; #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned EXPLODE_FRAMES = 32,
  parameter int unsigned INVULN_FRAMES  = 64
) (
  input logic             frame_clk,
  input logic             Reset,
  ship_collision_if.slave bus
);

  localparam int unsigned CntMax = (EXPLODE_FRAMES > INVULN_FRAMES) ?
                                   EXPLODE_FRAMES : INVULN_FRAMES;
  // At least 5 bits so ExplodeFrame can always take bits [4:2].
  localparam int unsigned CntW   = ($clog2(CntMax) < 5) ? 5 : $clog2(CntMax);

  localparam logic [CntW-1:0] ExplodeLast = CntW'(EXPLODE_FRAMES - 1);
  localparam logic [CntW-1:0] InvulnLast  = CntW'(INVULN_FRAMES - 1);

  logic [NumHaz-1:0] hazOverlap;
  shipState_t        state;
  logic [CntW-1:0]   frameCnt;
  logic [CntW-1:0]   cntInc;

  for (genvar i = 0; i < NumHaz; i++) begin : gHaz
    box_overlap uOverlap (
      .ShipX    (bus.ShipX),
      .ShipY    (bus.ShipY),
      .HazX     (bus.HazX[i]),
      .HazY     (bus.HazY[i]),
      .HazValid (bus.HazValid[i]),
      .Overlap  (hazOverlap[i])
    );
  end

  assign cntInc = frameCnt + CntW'(1);

  // Single FSM: the frame counter is shared by EXPLODE and RESPAWN and cleared
  // on every state entry; outputs are updated alongside the state.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state            <= ALIVE;
      frameCnt         <= '0;
      bus.Lives        <= 2'(LIVES_INIT);
      bus.ShipColl     <= 1'b0;
      bus.HitPulse     <= 1'b0;
      bus.HazKill      <= '0;
      bus.GameOver     <= 1'b0;
      bus.ExplodeFrame <= '0;
    end else begin
      bus.HitPulse <= 1'b0;
      bus.HazKill  <= '0;
      unique case (state)
        ALIVE: begin
          if (|hazOverlap) begin
            state            <= EXPLODE;
            frameCnt         <= '0;
            bus.HitPulse     <= 1'b1;
            bus.HazKill      <= hazOverlap;
            bus.ShipColl     <= 1'b1;
            bus.ExplodeFrame <= '0;
            if (bus.Lives != 2'd0) begin
              bus.Lives <= bus.Lives - 2'd1;
            end
          end
        end
        EXPLODE: begin
          if (frameCnt == ExplodeLast) begin
            frameCnt         <= '0;
            bus.ExplodeFrame <= '0;
            if (bus.Lives != 2'd0) begin
              state        <= RESPAWN;
              bus.ShipColl <= 1'b0;
            end else begin
              state        <= DEAD;
              bus.GameOver <= 1'b1;
            end
          end else begin
            frameCnt         <= cntInc;
            bus.ExplodeFrame <= cntInc[4:2];
          end
        end
        RESPAWN: begin
          // Ship visible but ignores hits until the timer expires.
          if (frameCnt == InvulnLast) begin
            state    <= ALIVE;
            frameCnt <= '0;
          end else begin
            frameCnt <= cntInc;
          end
        end
        DEAD: begin
          // Held until Reset.
        end
        default: begin
          state    <= ALIVE;
          frameCnt <= '0;
        end
      endcase
    end
  end

endmodule
